// File: rtl/ser_port_pkg.sv
// rtl/ser_port_pkg.sv - shared register offsets, FSM states and helpers for ser_port
//
// Purpose: common definitions used by the serial port top level and its receiver.
//   - SER_* : register offsets decoded from bus address bits [3:2]
//   - ser_state_e : 2-bit state encoding shared by the receive and transmit FSMs
//   - ctrl_word() : packs an interrupt-enable / ready pair into a control register read value
package ser_port_pkg;

  localparam logic [1:0] SER_RCV_CTRL = 2'd0;
  localparam logic [1:0] SER_RCV_DATA = 2'd1;
  localparam logic [1:0] SER_XMT_CTRL = 2'd2;
  localparam logic [1:0] SER_XMT_DATA = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } ser_state_e;

  function automatic logic [7:0] ctrl_word(input logic ie, input logic ready);
    return {6'b0, ie, ready};
  endfunction

endpackage

// File: rtl/ser_port_if.sv
// rtl/ser_port_if.sv - byte-wide register bus between the bus controller and ser_port
//
// Purpose: groups the register access signals of one serial port.
// Signals:
//   en       device selected for the current bus cycle
//   wr       1 = write, 0 = read (valid while en=1)
//   addr     register select (bus address bits [3:2])
//   data_in  write data
//   data_out registered read data, valid in the cycle where wt=0
//   wt       wait; the access completes in the first cycle with en=1 and wt=0
// Modports: master = bus controller side, slave = ser_port side.
interface ser_port_if;

  logic       en;
  logic       wr;
  logic [1:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       wt;

  modport master (
    output en, wr, addr, data_in,
    input  data_out, wt
  );

  modport slave (
    input  en, wr, addr, data_in,
    output data_out, wt
  );

endinterface

// File: rtl/ser_port_rcv.sv
// rtl/ser_port_rcv.sv - 8N1 serial receiver with input synchronizer and receive buffer
//
// Purpose: synchronizes rxd, detects a start bit, samples 8 data bits LSB first at
// mid-bit and checks the stop bit. A frame with a good stop bit is copied into the
// receive buffer; a framing error discards the byte.
// Ports:
//   clk      in   system clock
//   reset    in   synchronous, active-high reset
//   rxd      in   asynchronous serial input
//   rx_byte  out  receive buffer (last good byte)
//   rx_done  out  1-cycle strobe, high in the cycle the buffer is loaded at the next edge
module ser_port_rcv
  import ser_port_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1302
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       rx_done
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  logic       rxd_meta;
  logic       rxd_s;
  ser_state_e state_q, state_n;
  logic [15:0] timer_q, timer_n;
  logic [2:0]  idx_q, idx_n;
  logic [7:0]  shreg_q, shreg_n;
  logic [7:0]  buf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      idx_q    <= '0;
      shreg_q  <= '0;
      buf_q    <= '0;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
      state_q  <= state_n;
      timer_q  <= timer_n;
      idx_q    <= idx_n;
      shreg_q  <= shreg_n;
      if (rx_done) buf_q <= shreg_q;
    end
  end

  // The half-bit wait in START centres every later sample in its bit cell.
  always_comb begin
    state_n = state_q;
    timer_n = timer_q;
    idx_n   = idx_q;
    shreg_n = shreg_q;
    rx_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rxd_s) begin
          state_n = ST_START;
          timer_n = HALF_LAST;
        end
      end
      ST_START: begin
        if (timer_q == 16'd0) begin
          if (rxd_s) begin
            state_n = ST_IDLE;     // start bit did not persist: glitch
          end else begin
            state_n = ST_DATA;
            timer_n = BIT_LAST;
            idx_n   = 3'd0;
          end
        end else begin
          timer_n = timer_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (timer_q == 16'd0) begin
          shreg_n = {rxd_s, shreg_q[7:1]};
          timer_n = BIT_LAST;
          if (idx_q == 3'd7) state_n = ST_STOP;
          else               idx_n   = idx_q + 3'd1;
        end else begin
          timer_n = timer_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (timer_q == 16'd0) begin
          rx_done = rxd_s;         // stop bit low: framing error, byte dropped
          state_n = ST_IDLE;
        end else begin
          timer_n = timer_q - 16'd1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign rx_byte = buf_q;

endmodule

// File: rtl/ser_port.sv
// rtl/ser_port.sv - 8N1 serial port with register interface and rx/tx interrupts
//
// Purpose: one serial line device. Converts byte-wide register accesses into
// serial traffic, holds the transmitter and the register file, and instantiates
// the receiver.
// Ports:
//   clk    in    system clock
//   reset  in    synchronous, active-high reset
//   bus    slave register bus (en, wr, addr, data_in, data_out, wt)
//   irq_r  out   receive interrupt, registered rcv_ready & rcv_ie
//   irq_t  out   transmit interrupt, registered xmt_ready & xmt_ie
//   rxd    in    asynchronous serial input
//   txd    out   serial output, idle high
// Registers (addr): 0 rcv ctrl {rcv_ie, rcv_ready}, 1 rcv data, 2 xmt ctrl {xmt_ie, xmt_ready}, 3 xmt data.
module ser_port
  import ser_port_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1302
) (
  input  logic       clk,
  input  logic       reset,
  ser_port_if.slave  bus,
  output logic       irq_r,
  output logic       irq_t,
  input  logic       rxd,
  output logic       txd
);

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  // bus handshake: one wait state, data_out loaded during the wait cycle,
  // side effects applied at the completion edge only
  logic       ack_q;
  logic       complete;
  logic       rd_setup;
  logic       wr_done;
  logic       rd_done;
  logic [7:0] rd_data;
  logic [7:0] data_out_q;

  logic rcv_ie_q, rcv_ready_q;
  logic xmt_ie_q, xmt_ready_q, xmt_ready_n;
  logic [7:0] rcv_buf;
  logic       rcv_done;
  logic       rcv_clear;
  logic       xmt_load;

  ser_state_e  tx_state_q, tx_state_n;
  logic [15:0] tx_timer_q, tx_timer_n;
  logic [2:0]  tx_idx_q, tx_idx_n;
  logic [7:0]  tx_shreg_q, tx_shreg_n;
  logic        txd_q, txd_n;

  assign complete = bus.en & ack_q;
  assign rd_setup = bus.en & ~ack_q & ~bus.wr;
  assign wr_done  = complete & bus.wr;
  assign rd_done  = complete & ~bus.wr;
  assign bus.wt   = bus.en & ~ack_q;
  assign bus.data_out = data_out_q;

  assign rcv_clear = rd_done & (bus.addr == SER_RCV_DATA);
  // A write landing on the edge where ready sets still sees the old 0 and is dropped.
  assign xmt_load  = wr_done & (bus.addr == SER_XMT_DATA) & xmt_ready_q;

  always_comb begin
    rd_data = 8'h00;
    case (bus.addr)
      SER_RCV_CTRL: rd_data = ctrl_word(rcv_ie_q, rcv_ready_q);
      SER_RCV_DATA: rd_data = rcv_buf;
      SER_XMT_CTRL: rd_data = ctrl_word(xmt_ie_q, xmt_ready_q);
      default:      rd_data = 8'h00;
    endcase
  end

  ser_port_rcv #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rcv (
    .clk     (clk),
    .reset   (reset),
    .rxd     (rxd),
    .rx_byte (rcv_buf),
    .rx_done (rcv_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q       <= 1'b0;
      data_out_q  <= 8'h00;
      rcv_ie_q    <= 1'b0;
      rcv_ready_q <= 1'b0;
      xmt_ie_q    <= 1'b0;
      xmt_ready_q <= 1'b1;
      irq_r       <= 1'b0;
      irq_t       <= 1'b0;
    end else begin
      ack_q <= bus.en & ~ack_q;
      if (rd_setup) data_out_q <= rd_data;
      if (wr_done && bus.addr == SER_RCV_CTRL) rcv_ie_q <= bus.data_in[1];
      if (wr_done && bus.addr == SER_XMT_CTRL) xmt_ie_q <= bus.data_in[1];
      // a byte arriving in the same cycle as a data read keeps ready set
      if (rcv_done)       rcv_ready_q <= 1'b1;
      else if (rcv_clear) rcv_ready_q <= 1'b0;
      xmt_ready_q <= xmt_ready_n;
      irq_r <= rcv_ready_q & rcv_ie_q;
      irq_t <= xmt_ready_q & xmt_ie_q;
    end
  end

  // transmitter state register
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= ST_IDLE;
      tx_timer_q <= '0;
      tx_idx_q   <= '0;
      tx_shreg_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_n;
      tx_timer_q <= tx_timer_n;
      tx_idx_q   <= tx_idx_n;
      tx_shreg_q <= tx_shreg_n;
      txd_q      <= txd_n;
    end
  end

  // transmitter next state; txd is registered from the next-state view so it
  // changes in the cycle right after the accepted write
  always_comb begin
    tx_state_n  = tx_state_q;
    tx_timer_n  = tx_timer_q;
    tx_idx_n    = tx_idx_q;
    tx_shreg_n  = tx_shreg_q;
    xmt_ready_n = xmt_ready_q;
    case (tx_state_q)
      ST_IDLE: ;
      ST_START: begin
        if (tx_timer_q == 16'd0) begin
          tx_state_n = ST_DATA;
          tx_timer_n = BIT_LAST;
          tx_idx_n   = 3'd0;
        end else begin
          tx_timer_n = tx_timer_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (tx_timer_q == 16'd0) begin
          tx_timer_n = BIT_LAST;
          if (tx_idx_q == 3'd7) begin
            tx_state_n = ST_STOP;
          end else begin
            tx_idx_n   = tx_idx_q + 3'd1;
            tx_shreg_n = {1'b0, tx_shreg_q[7:1]};
          end
        end else begin
          tx_timer_n = tx_timer_q - 16'd1;
        end
      end
      ST_STOP: begin
        // ready rises for the final stop cycle so write-to-ready is ten bit times
        if (tx_timer_q == 16'd1) xmt_ready_n = 1'b1;
        if (tx_timer_q == 16'd0) tx_state_n = ST_IDLE;
        else                     tx_timer_n = tx_timer_q - 16'd1;
      end
      default: tx_state_n = ST_IDLE;
    endcase
    // a load may also arrive in the last stop cycle, chaining the next frame
    if (xmt_load) begin
      tx_state_n  = ST_START;
      tx_timer_n  = BIT_LAST;
      tx_shreg_n  = bus.data_in;
      xmt_ready_n = 1'b0;
    end
    case (tx_state_n)
      ST_START: txd_n = 1'b0;
      ST_DATA:  txd_n = tx_shreg_n[0];
      default:  txd_n = 1'b1;
    endcase
  end

  assign txd = txd_q;

endmodule

// File: tb/tb_ser_port.sv
// tb/tb_ser_port.sv - self-checking bench for ser_port
//
// Purpose: directed and randomized register accesses and serial frames, checked
// against a frame-level model of the serial port kept in the bench.
module tb_ser_port;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rxd = 1'b1;
  logic irq_r, irq_t, txd;

  int tests = 0;
  int fails = 0;

  ser_port_if bus();

  ser_port #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .irq_r (irq_r),
    .irq_t (irq_t),
    .rxd   (rxd),
    .txd   (txd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // expected line level of frame bit k (0 = start, 1..8 = data LSB first, 9 = stop)
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  // called at posedge+1; returns at posedge+1 just after the completion edge
  task automatic bus_acc(input logic w, input logic [1:0] a, input logic [7:0] d,
                         output logic [7:0] rdv);
    int waits;
    bit done;
    waits = 0;
    done = 0;
    rdv = 'x;
    bus.en = 1'b1;
    bus.wr = w;
    bus.addr = a;
    bus.data_in = d;
    for (int i = 0; i < 6 && !done; i++) begin
      @(negedge clk);
      if (bus.wt) waits++;
      else begin
        rdv = bus.data_out;
        done = 1;
      end
    end
    @(posedge clk);
    #1;
    bus.en = 1'b0;
    check("access_completes", 32'(done), 32'd1);
    check("one_wait_state", waits, 1);
  endtask

  task automatic reg_rd(input logic [1:0] a, output logic [7:0] v);
    bus_acc(1'b0, a, 8'h00, v);
  endtask

  task automatic reg_wr(input logic [1:0] a, input logic [7:0] d);
    logic [7:0] unused;
    bus_acc(1'b1, a, d, unused);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    for (int k = 0; k < 10; k++) begin
      rxd = (k == 9) ? stop : frame_bit(b, k);
      repeat (CPB) @(posedge clk);
      #1;
    end
    rxd = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // called right after the accepted write; checks first and last cycle of every bit
  task automatic check_tx_frame(input logic [7:0] b, input string tag);
    for (int c = 0; c < 10 * CPB; c++) begin
      @(negedge clk);
      if (c % CPB == 0 || c % CPB == CPB - 1)
        check(tag, 32'(txd), 32'(frame_bit(b, c / CPB)));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] b;
    logic stop_ok;
    logic [7:0] m_buf;
    logic m_rdy;

    bus.en = 1'b0;
    bus.wr = 1'b0;
    bus.addr = 2'd0;
    bus.data_in = 8'h00;

    // 1: reset state and basic reads
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_txd", 32'(txd), 32'd1);
    check("reset_irq_r", 32'(irq_r), 32'd0);
    check("reset_irq_t", 32'(irq_t), 32'd0);
    check("reset_data_out", 32'(bus.data_out), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    reg_rd(2'd2, v); check("xmt_ctrl_after_reset", 32'(v), 32'h01);
    reg_rd(2'd0, v); check("rcv_ctrl_after_reset", 32'(v), 32'h00);
    reg_rd(2'd3, v); check("xmt_data_reads_zero", 32'(v), 32'h00);
    reg_wr(2'd2, 8'h02);
    repeat (2) @(negedge clk);
    check("irq_t_enabled", 32'(irq_t), 32'd1);
    @(posedge clk);
    #1;

    // 2: transmit A5, then busy flag and dropped write
    reg_wr(2'd3, 8'hA5);
    check_tx_frame(8'hA5, "tx_A5_bit");
    reg_rd(2'd2, v); check("xmt_ready_after_frame", 32'(v), 32'h03);
    b = 8'($urandom);
    reg_wr(2'd3, b);
    reg_rd(2'd2, v); check("xmt_busy_during_frame", 32'(v), 32'h02);
    @(negedge clk);
    check("irq_t_low_while_busy", 32'(irq_t), 32'd0);
    @(posedge clk);
    #1;
    reg_wr(2'd3, ~b);
    repeat (170) @(posedge clk);
    #1;
    reg_rd(2'd2, v); check("xmt_ready_again", 32'(v), 32'h03);
    for (int i = 0; i < 5; i++) begin
      repeat (8) @(negedge clk);
      check("no_frame_for_dropped_write", 32'(txd), 32'd1);
    end
    @(posedge clk);
    #1;
    reg_wr(2'd2, 8'h00);

    // 3: receive 3C
    send_frame(8'h3C, 1'b1);
    reg_rd(2'd0, v); check("rcv_ready_3C", 32'(v), 32'h01);
    reg_rd(2'd1, v); check("rcv_data_3C", 32'(v), 32'h3C);
    reg_rd(2'd0, v); check("rcv_ready_cleared", 32'(v), 32'h00);

    // 4: receive interrupt
    reg_wr(2'd0, 8'h02);
    send_frame(8'h55, 1'b1);
    @(negedge clk);
    check("irq_r_set", 32'(irq_r), 32'd1);
    @(posedge clk);
    #1;
    reg_rd(2'd1, v); check("rcv_data_55", 32'(v), 32'h55);
    @(negedge clk);
    check("irq_r_still_set", 32'(irq_r), 32'd1);
    @(negedge clk);
    check("irq_r_cleared", 32'(irq_r), 32'd0);
    @(posedge clk);
    #1;
    reg_wr(2'd0, 8'h00);

    // 5: overrun and framing error
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h99, 1'b0);
    repeat (24) @(posedge clk);
    #1;
    reg_rd(2'd0, v); check("rcv_ready_overrun", 32'(v), 32'h01);
    reg_rd(2'd1, v); check("rcv_data_overrun", 32'(v), 32'h22);
    reg_rd(2'd0, v); check("rcv_ready_after_overrun", 32'(v), 32'h00);

    // 6: reset mid-frame, then a short rxd glitch
    reg_wr(2'd3, 8'hE5);
    repeat (85) @(posedge clk);
    @(negedge clk);
    check("tx_bit4_before_reset", 32'(txd), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("txd_high_after_reset", 32'(txd), 32'd1);
    @(posedge clk);
    #1;
    reg_rd(2'd2, v); check("xmt_ready_after_reset", 32'(v), 32'h01);
    rxd = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rxd = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    reg_rd(2'd0, v); check("glitch_no_byte", 32'(v), 32'h00);
    check("txd_idle_after_glitch", 32'(txd), 32'd1);

    // randomized receive against a buffer/ready model
    m_buf = 8'h00;
    m_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      stop_ok = ($urandom_range(0, 3) != 0);
      send_frame(b, stop_ok);
      repeat (24) @(posedge clk);
      #1;
      if (stop_ok) begin
        m_buf = b;
        m_rdy = 1'b1;
      end
      reg_rd(2'd0, v); check("rand_rcv_ctrl", 32'(v), {30'd0, 1'b0, m_rdy});
      if ($urandom_range(0, 1) == 1) begin
        reg_rd(2'd1, v); check("rand_rcv_data", 32'(v), 32'(m_buf));
        m_rdy = 1'b0;
      end
    end

    // randomized back-to-back transmit
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      reg_wr(2'd3, b);
      check_tx_frame(b, "rand_tx_bit");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
